// File: rtl/mem_port_pkg.sv
// Shared encodings for the RAM port arbiter: access sizes, direction,
// FSM states, grant owner and the load-data size mask.
package mem_port_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR_STROBE,
    ST_RESP
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  function automatic logic [31:0] size_mask(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 32'h0000_00FF;
      SIZE_HALF: return 32'h0000_FFFF;
      default:   return 32'hFFFF_FFFF;
    endcase
  endfunction
endpackage

// File: rtl/mem_align_check.sv
// Natural-alignment check for one request: halfwords on even, words on
// 4-byte boundaries; size 11 is always rejected.
module mem_align_check
  import mem_port_pkg::*;
(
  input  logic [1:0] size_i,
  input  logic [1:0] addr_lsb_i,
  output logic       err_o
);

  always_comb begin
    case (size_i)
      SIZE_BYTE: err_o = 1'b0;
      SIZE_HALF: err_o = addr_lsb_i[0];
      SIZE_WORD: err_o = |addr_lsb_i;
      default:   err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester front end for the single big-endian RAM port: fetch vs data
// arbitration with starvation guard, and req/ack sequencing of RAM reads/writes.
//
//   state        | meaning
//   IDLE         | sample requests, grant, latch access; MemEnable low
//   RD           | MemEnable high for a read; RAM data captured at cycle end
//   WR_SETUP     | address/size/data stable, MemEnable low
//   WR_STROBE    | MemEnable rises, committing the write
//   RESP         | owner's Ack pulse with RData/Err; MemEnable low
module mem_port_arbiter
  import mem_port_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              I_Req,
  input  logic [ADDR_W-1:0] I_Addr,
  output logic              I_Ack,
  output logic [31:0]       I_RData,
  output logic              I_Err,
  input  logic              D_Req,
  input  logic              D_RW,
  input  logic [1:0]        D_Size,
  input  logic [ADDR_W-1:0] D_Addr,
  input  logic [31:0]       D_WData,
  output logic              D_Ack,
  output logic [31:0]       D_RData,
  output logic              D_Err,
  output logic              MemEnable,
  output logic              MemReadWrite,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [1:0]        MemSize,
  output logic [31:0]       MemDataIn,
  input  logic [31:0]       MemDataOut,
  output logic              Busy
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  state_e              state_q;
  owner_e              owner_q;
  logic [CNT_W-1:0]    starve_q;
  logic                i_ack_q, i_err_q, d_ack_q, d_err_q;
  logic [31:0]         i_rdata_q, d_rdata_q;
  logic                mem_en_q, mem_rw_q, busy_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [1:0]          mem_size_q;
  logic [31:0]         mem_wdata_q;
  logic                i_misalign, d_misalign, fetch_win;

  mem_align_check u_align_i (
    .size_i     (SIZE_WORD),
    .addr_lsb_i (I_Addr[1:0]),
    .err_o      (i_misalign)
  );

  mem_align_check u_align_d (
    .size_i     (D_Size),
    .addr_lsb_i (D_Addr[1:0]),
    .err_o      (d_misalign)
  );

  // Data normally wins; fetch wins when alone or once data has starved it long enough.
  assign fetch_win = I_Req && (!D_Req || (starve_q == STARVE_LIM));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_I;
      starve_q    <= '0;
      i_ack_q     <= 1'b0;
      i_err_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_rw_q    <= RW_READ;
      mem_addr_q  <= '0;
      mem_size_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!I_Req) starve_q <= '0;
          if (fetch_win) begin
            owner_q  <= OWN_I;
            starve_q <= '0;
            busy_q   <= 1'b1;
            if (i_misalign) begin
              state_q   <= ST_RESP;
              i_ack_q   <= 1'b1;
              i_err_q   <= 1'b1;
              i_rdata_q <= '0;
            end else begin
              state_q    <= ST_RD;
              mem_en_q   <= 1'b1;
              mem_rw_q   <= RW_READ;
              mem_addr_q <= I_Addr;
              mem_size_q <= SIZE_WORD;
            end
          end else if (D_Req) begin
            owner_q <= OWN_D;
            busy_q  <= 1'b1;
            if (I_Req && (starve_q != STARVE_LIM)) starve_q <= starve_q + 1'b1;
            // Rejected accesses leave every Mem* output untouched.
            if (d_misalign) begin
              state_q   <= ST_RESP;
              d_ack_q   <= 1'b1;
              d_err_q   <= 1'b1;
              d_rdata_q <= '0;
            end else begin
              mem_addr_q <= D_Addr;
              mem_size_q <= D_Size;
              mem_rw_q   <= D_RW;
              if (D_RW == RW_WRITE) begin
                state_q     <= ST_WR_SETUP;
                mem_wdata_q <= D_WData;
              end else begin
                state_q  <= ST_RD;
                mem_en_q <= 1'b1;
              end
            end
          end
        end
        ST_RD: begin
          mem_en_q <= 1'b0;
          state_q  <= ST_RESP;
          if (owner_q == OWN_I) begin
            i_ack_q   <= 1'b1;
            i_err_q   <= 1'b0;
            i_rdata_q <= MemDataOut;
          end else begin
            d_ack_q   <= 1'b1;
            d_err_q   <= 1'b0;
            d_rdata_q <= MemDataOut & size_mask(mem_size_q);
          end
        end
        ST_WR_SETUP: begin
          mem_en_q <= 1'b1;
          state_q  <= ST_WR_STROBE;
        end
        ST_WR_STROBE: begin
          mem_en_q  <= 1'b0;
          state_q   <= ST_RESP;
          d_ack_q   <= 1'b1;
          d_err_q   <= 1'b0;
          d_rdata_q <= '0;
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= ST_IDLE;
          mem_en_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign I_Ack        = i_ack_q;
  assign I_RData      = i_rdata_q;
  assign I_Err        = i_err_q;
  assign D_Ack        = d_ack_q;
  assign D_RData      = d_rdata_q;
  assign D_Err        = d_err_q;
  assign MemEnable    = mem_en_q;
  assign MemReadWrite = mem_rw_q;
  assign MemAddress   = mem_addr_q;
  assign MemSize      = mem_size_q;
  assign MemDataIn    = mem_wdata_q;
  assign Busy         = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte-array RAM model, directed vector table,
// arbitration and reset corner sequences, then random traffic vs a memory model.
module tb_mem_port_arbiter;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        I_Req = 1'b0;
  logic [7:0]  I_Addr = '0;
  logic        I_Ack;
  logic [31:0] I_RData;
  logic        I_Err;
  logic        D_Req = 1'b0;
  logic        D_RW = 1'b0;
  logic [1:0]  D_Size = '0;
  logic [7:0]  D_Addr = '0;
  logic [31:0] D_WData = '0;
  logic        D_Ack;
  logic [31:0] D_RData;
  logic        D_Err;
  logic        MemEnable;
  logic        MemReadWrite;
  logic [7:0]  MemAddress;
  logic [1:0]  MemSize;
  logic [31:0] MemDataIn;
  logic [31:0] MemDataOut;
  logic        Busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(8), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .I_Req(I_Req), .I_Addr(I_Addr), .I_Ack(I_Ack), .I_RData(I_RData), .I_Err(I_Err),
    .D_Req(D_Req), .D_RW(D_RW), .D_Size(D_Size), .D_Addr(D_Addr), .D_WData(D_WData),
    .D_Ack(D_Ack), .D_RData(D_RData), .D_Err(D_Err),
    .MemEnable(MemEnable), .MemReadWrite(MemReadWrite), .MemAddress(MemAddress),
    .MemSize(MemSize), .MemDataIn(MemDataIn), .MemDataOut(MemDataOut), .Busy(Busy)
  );

  logic [7:0] ram [256];
  logic [7:0] ref_mem [256];
  int rises = 0;
  int n_checks = 0;
  int n_err = 0;

  // RAM read port: only meaningful while enabled for a read, junk otherwise.
  always_comb begin
    MemDataOut = 32'hA5A5_A5A5;
    if (MemEnable && !MemReadWrite) begin
      case (MemSize)
        2'b00:   MemDataOut = {24'h0, ram[MemAddress]};
        2'b01:   MemDataOut = {16'h0, ram[MemAddress], ram[MemAddress + 8'd1]};
        default: MemDataOut = {ram[MemAddress], ram[MemAddress + 8'd1],
                               ram[MemAddress + 8'd2], ram[MemAddress + 8'd3]};
      endcase
    end
  end

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [7:0] a, input logic [1:0] s);
    logic [31:0] v = '0;
    for (int i = 0; i < nbytes(s); i++) v = (v << 8) | {24'h0, ref_mem[8'(a + i)]};
    return v;
  endfunction

  task automatic ref_store(input logic [7:0] a, input logic [1:0] s, input logic [31:0] d);
    for (int i = 0; i < nbytes(s); i++) ref_mem[8'(a + i)] = d[8*(nbytes(s)-1-i) +: 8];
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_txn(input logic own_i, input logic rw, input logic [1:0] size,
                        input logic [7:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output logic [3:0] en_tr, output logic busy1, output int rise_d);
    int r0;
    logic got;
    r0 = rises; got = 1'b0; lat = -1; rdata = '0; err = 1'b0; en_tr = '0; busy1 = 1'b0;
    if (own_i) begin
      I_Addr = addr; I_Req = 1'b1;
    end else begin
      D_RW = rw; D_Size = size; D_Addr = addr; D_WData = wdata; D_Req = 1'b1;
    end
    for (int c = 1; c <= 8 && !got; c++) begin
      @(posedge clk); #1;
      if (c <= 3) en_tr[c] = MemEnable;
      if (c == 1) busy1 = Busy;
      if (own_i ? I_Ack : D_Ack) begin
        got = 1'b1; lat = c;
        rdata = own_i ? I_RData : D_RData;
        err = own_i ? I_Err : D_Err;
      end
    end
    I_Req = 1'b0; D_Req = 1'b0;
    @(posedge clk); #1;
    rise_d = rises - r0;
  endtask

  task automatic run_vec(input string tag, input logic own_i, input logic rw,
                         input logic [1:0] size, input logic [7:0] addr, input logic [31:0] wdata,
                         input logic exp_err, input int exp_lat, input logic [31:0] exp_rd,
                         input logic chk_rd, input logic [3:0] exp_en);
    int lat, rise_d;
    logic [31:0] rdata;
    logic err, busy1;
    logic [3:0] en_tr;
    do_txn(own_i, rw, size, addr, wdata, lat, rdata, err, en_tr, busy1, rise_d);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_err"}, {31'h0, err}, {31'h0, exp_err});
    if (chk_rd) chk({tag, "_rdata"}, rdata, exp_rd);
    chk({tag, "_enable_trace"}, {28'h0, en_tr}, {28'h0, exp_en});
    chk({tag, "_enable_rises"}, rise_d, exp_err ? 0 : 1);
    chk({tag, "_busy"}, {31'h0, busy1}, 32'h1);
    if (!exp_err) chk({tag, "_addr_hold"}, {24'h0, MemAddress}, {24'h0, addr});
  endtask

  typedef struct {
    logic        own_i;
    logic        rw;
    logic [1:0]  size;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_rd;
    logic [3:0]  exp_en;
  } vec_t;

  vec_t vecs [15];
  int r0, n_ack, cnt_m, diffs;
  logic dual, exp_i, ack_seen, en_seen, own, rw, e;
  logic [1:0] size;
  logic [7:0] addr;
  logic [31:0] wdata;
  int sz, lat;
  logic [3:0] en;

  initial begin
    //        own   rw    size   addr   wdata          err   lat rdata          en
    vecs[0]  = '{1'b0, 1'b1, 2'b10, 8'h10, 32'hDEADBEEF, 1'b0, 3, 32'h0,        4'b0100};
    vecs[1]  = '{1'b0, 1'b0, 2'b10, 8'h10, 32'h0,        1'b0, 2, 32'hDEADBEEF, 4'b0010};
    vecs[2]  = '{1'b0, 1'b1, 2'b01, 8'h20, 32'h00001234, 1'b0, 3, 32'h0,        4'b0100};
    vecs[3]  = '{1'b0, 1'b0, 2'b00, 8'h21, 32'h0,        1'b0, 2, 32'h00000034, 4'b0010};
    vecs[4]  = '{1'b0, 1'b0, 2'b01, 8'h20, 32'h0,        1'b0, 2, 32'h00001234, 4'b0010};
    vecs[5]  = '{1'b0, 1'b0, 2'b10, 8'h22, 32'h0,        1'b1, 1, 32'h0,        4'b0000};
    vecs[6]  = '{1'b0, 1'b1, 2'b01, 8'h23, 32'h0000BEEF, 1'b1, 1, 32'h0,        4'b0000};
    vecs[7]  = '{1'b0, 1'b0, 2'b11, 8'h30, 32'h0,        1'b1, 1, 32'h0,        4'b0000};
    vecs[8]  = '{1'b1, 1'b0, 2'b10, 8'hFC, 32'h0,        1'b0, 2, 32'h11223344, 4'b0010};
    vecs[9]  = '{1'b1, 1'b0, 2'b10, 8'h02, 32'h0,        1'b1, 1, 32'h0,        4'b0000};
    vecs[10] = '{1'b0, 1'b1, 2'b00, 8'h40, 32'h000000AB, 1'b0, 3, 32'h0,        4'b0100};
    vecs[11] = '{1'b0, 1'b0, 2'b10, 8'h40, 32'h0,        1'b0, 2, 32'hAB000000, 4'b0010};
    vecs[12] = '{1'b0, 1'b0, 2'b00, 8'h13, 32'h0,        1'b0, 2, 32'h000000EF, 4'b0010};
    vecs[13] = '{1'b0, 1'b1, 2'b10, 8'h44, 32'hCAFEF00D, 1'b0, 3, 32'h0,        4'b0100};
    vecs[14] = '{1'b0, 1'b0, 2'b01, 8'h46, 32'h0,        1'b0, 2, 32'h0000F00D, 4'b0010};

    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    ram[8'hFC] = 8'h11; ram[8'hFD] = 8'h22; ram[8'hFE] = 8'h33; ram[8'hFF] = 8'h44;
    ref_mem[8'hFC] = 8'h11; ref_mem[8'hFD] = 8'h22; ref_mem[8'hFE] = 8'h33; ref_mem[8'hFF] = 8'h44;
    ram[8'h50] = 8'h11; ref_mem[8'h50] = 8'h11;

    // RAM write port: commits on each rising edge of MemEnable while in write mode.
    fork
      forever begin
        @(posedge MemEnable);
        rises++;
        if (MemReadWrite)
          for (int i = 0; i < nbytes(MemSize); i++)
            ram[MemAddress + 8'(i)] = MemDataIn[8*(nbytes(MemSize)-1-i) +: 8];
      end
    join_none

    #1 reset = 1'b1;
    #2;
    chk("reset_outputs_zero", {31'h0, |{I_Ack, I_RData, I_Err, D_Ack, D_RData, D_Err, MemEnable,
        MemReadWrite, MemAddress, MemSize, MemDataIn, Busy}}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i].own_i, vecs[i].rw, vecs[i].size, vecs[i].addr,
              vecs[i].wdata, vecs[i].exp_err, vecs[i].exp_lat, vecs[i].exp_rd,
              !vecs[i].rw || vecs[i].exp_err, vecs[i].exp_en);
      if (vecs[i].rw && !vecs[i].exp_err && !vecs[i].own_i)
        ref_store(vecs[i].addr, vecs[i].size, vecs[i].wdata);
    end
    chk("err_store_untouched", {16'h0, ram[8'h23], ram[8'h24]}, 32'h0);

    // Both requesters held continuously: fetch is served after STARVE_MAX data grants.
    D_RW = 1'b0; D_Size = 2'b10; D_Addr = 8'h10; I_Addr = 8'hFC;
    I_Req = 1'b1; D_Req = 1'b1;
    cnt_m = 0; n_ack = 0; dual = 1'b0;
    for (int c = 0; c < 200 && n_ack < 10; c++) begin
      @(posedge clk); #1;
      if (I_Ack && D_Ack) dual = 1'b1;
      if (I_Ack || D_Ack) begin
        exp_i = (cnt_m == STARVE_MAX);
        cnt_m = exp_i ? 0 : cnt_m + 1;
        chk($sformatf("arb_grant%0d_is_fetch", n_ack), {31'h0, I_Ack}, {31'h0, exp_i});
        chk($sformatf("arb_rdata%0d", n_ack), I_Ack ? I_RData : D_RData,
            exp_i ? ref_load(8'hFC, 2'b10) : ref_load(8'h10, 2'b10));
        n_ack++;
      end
    end
    I_Req = 1'b0; D_Req = 1'b0;
    chk("arb_ack_count", n_ack, 10);
    chk("arb_no_dual_ack", {31'h0, dual}, 32'h0);
    repeat (2) @(posedge clk); #1;

    // Reset while in WR_SETUP: the write must never reach the RAM.
    r0 = rises; ack_seen = 1'b0; en_seen = 1'b0;
    D_RW = 1'b1; D_Size = 2'b00; D_Addr = 8'h50; D_WData = 32'h00000099; D_Req = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1; D_Req = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      ack_seen |= I_Ack | D_Ack; en_seen |= MemEnable;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    ack_seen |= I_Ack | D_Ack; en_seen |= MemEnable;
    chk("rst_setup_no_ack", {31'h0, ack_seen}, 32'h0);
    chk("rst_setup_no_enable", {31'h0, en_seen}, 32'h0);
    chk("rst_setup_no_rise", rises - r0, 0);
    chk("rst_setup_byte", {24'h0, ram[8'h50]}, {24'h0, ref_mem[8'h50]});

    // Reset while in WR_STROBE: the write has already been committed.
    r0 = rises; ack_seen = 1'b0;
    D_Req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rst_strobe_outputs_zero", {31'h0, |{I_Ack, I_RData, I_Err, D_Ack, D_RData, D_Err, MemEnable,
        MemReadWrite, MemAddress, MemSize, MemDataIn, Busy}}, 32'h0);
    D_Req = 1'b0;
    ref_store(8'h50, 2'b00, 32'h00000099);
    repeat (2) begin
      @(posedge clk); #1;
      ack_seen |= I_Ack | D_Ack;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    ack_seen |= I_Ack | D_Ack;
    chk("rst_strobe_no_ack", {31'h0, ack_seen}, 32'h0);
    chk("rst_strobe_one_rise", rises - r0, 1);
    chk("rst_strobe_byte", {24'h0, ram[8'h50]}, {24'h0, ref_mem[8'h50]});

    for (int k = 0; k < 60; k++) begin
      own = ($urandom_range(0, 3) == 0);
      addr = 8'($urandom_range(0, 255));
      wdata = $urandom;
      if (own) begin
        rw = 1'b0; size = 2'b10;
        if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      end else begin
        rw = 1'($urandom_range(0, 1));
        sz = $urandom_range(0, 7);
        size = (sz >= 6) ? 2'b11 : 2'(sz % 3);
        if ($urandom_range(0, 1) == 1) addr = addr - 8'(addr % nbytes(size));
      end
      e = (size == 2'b11) || ((addr % nbytes(size)) != 0);
      lat = e ? 1 : (rw ? 3 : 2);
      en = e ? 4'b0000 : (rw ? 4'b0100 : 4'b0010);
      run_vec($sformatf("rnd%0d", k), own, rw, size, addr, wdata, e, lat,
              e ? 32'h0 : ref_load(addr, size), e || !rw, en);
      if (!e && rw) ref_store(addr, size, wdata);
    end

    diffs = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) diffs++;
    chk("ram_matches_model", diffs, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequencing controller and two-port arbiter in front of the byte-addressable, big-endian data/instruction RAM.
- Shares the single RAM port between the instruction-fetch requester (word reads only) and the data requester (byte/halfword/word loads and stores).
- Converts the RAM's level-enable read and edge-on-Enable write into a clocked req/ack protocol.
- Rejects misaligned accesses before they reach the RAM.

Parameters:
ADDR_W, 8, byte-address width presented to both requesters and the RAM.
STARVE_MAX, 4, consecutive data grants allowed while I_Req is pending before fetch is forced a grant.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
I_Req  input  1  fetch request, level; held until I_Ack.
I_Addr  input  ADDR_W  fetch byte address.
I_Ack  output  1  one-cycle completion pulse for fetch.
I_RData  output  32  fetched word, valid while I_Ack=1.
I_Err  output  1  misaligned fetch, valid while I_Ack=1.
D_Req  input  1  data request, level; held until D_Ack.
D_RW  input  1  0 = load, 1 = store.
D_Size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
D_Addr  input  ADDR_W  data byte address.
D_WData  input  32  store data, right-justified.
D_Ack  output  1  one-cycle completion pulse for data.
D_RData  output  32  zero-extended load data, valid while D_Ack=1.
D_Err  output  1  misaligned or illegal size, valid while D_Ack=1.
MemEnable  output  1  RAM enable; a rising edge with MemReadWrite=1 commits a write.
MemReadWrite  output  1  0 = read, 1 = write.
MemAddress  output  ADDR_W  RAM address.
MemSize  output  2  RAM access size.
MemDataIn  output  32  RAM write data.
MemDataOut  input  32  RAM read data; combinational while MemEnable=1 and MemReadWrite=0.
Busy  output  1  1 in any state other than IDLE.

Behaviour:
- Reset (async, active-high) values:
  - state = IDLE.
  - All outputs 0, including MemEnable, MemReadWrite, I_Ack and D_Ack.
  - Starve counter cleared.
- All outputs are registered.
- FSM states: IDLE, RD, WR_SETUP, WR_STROBE, RESP.
- IDLE, grant selection (requests sampled at the clock edge):
  - D_Req wins, unless I_Req=1 and starve_cnt==STARVE_MAX; then fetch wins.
  - On the grant edge, latch addr, size, rw, wdata and owner (I or D).
- Alignment check (combinational on the granted request):
  - Error if size 01 with addr[0]=1.
  - Error if size 10 with addr[1:0]!=0.
  - Error if size 11.
  - Fetch is always size 10.
  - On error: go to RESP with Err=1 and RData=0; no RAM activity.
- Normal next state from IDLE: load or fetch -> RD; store -> WR_SETUP.
- RD:
  - MemEnable=1, MemReadWrite=0.
  - MemDataOut is captured into the RData register at the end of the cycle.
  - -> RESP.
- WR_SETUP:
  - MemEnable=0, MemReadWrite=1.
  - MemAddress, MemSize and MemDataIn are driven stable.
  - -> WR_STROBE.
- WR_STROBE:
  - MemEnable=1; the rising edge commits the write.
  - Address, size and data are held unchanged.
  - -> RESP.
- RESP:
  - MemEnable=0.
  - The owner's Ack=1 for exactly one cycle, with RData and Err.
  - -> IDLE.
- Latency, counted from the sampling edge to the Ack-high cycle:
  - Load or fetch: 2 cycles.
  - Store: 3 cycles.
  - Error: 1 cycle.
- Back-to-back operation:
  - The requester drops Req in the cycle after Ack.
  - IDLE always lasts at least 1 cycle, so MemEnable is low for at least 1 cycle between accesses; this guarantees a fresh rising edge on every write.
- Starve counter:
  - Increments on a data grant while I_Req=1.
  - Clears on a fetch grant, or when I_Req=0 in IDLE.
  - Saturates at STARVE_MAX.
- Mem outputs hold their last value in IDLE and RESP; only MemEnable is forced 0.
- Simultaneous I_Req and D_Req with the counter below the limit: data is served, then fetch on the next IDLE.
- Reset mid-operation:
  - Immediate return to IDLE and MemEnable=0; no Ack is issued.
  - A write is committed only if WR_STROBE had already been entered.

Decomposition:
- Package mem_port_pkg holds:
  - Size encodings SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10.
  - RW_READ=0, RW_WRITE=1.
  - The FSM state enum.
  - Owner encoding.
- One natural sub-module: mem_align_check (combinational; size and addr in, err out). It is reused for both requesters.

Test Plan:
- Store, then load: D store word 0xDEADBEEF at 0x10 -> MemEnable low in WR_SETUP, rising in WR_STROBE, D_Ack 3 cycles after the sampling edge. Load word 0x10 -> D_RData=0xDEADBEEF with D_Ack 2 cycles after sampling.
- Halfword/byte loads: store half 0x1234 at 0x20, load byte 0x21 -> D_RData=0x00000034; load half 0x20 -> 0x00001234.
- Misalignment: load word at 0x22, then store half at 0x23, then D_Size=11 -> each gives D_Err=1 and D_Ack 1 cycle after sampling, MemEnable never asserted, memory unchanged.
- Arbitration: I_Req and D_Req both held continuously with STARVE_MAX=4 -> grant order D,D,D,D,I,D,D,D,D,I; no two Acks in the same cycle.
- Reset mid-write: assert reset during WR_SETUP -> MemEnable stays 0, no D_Ack, target byte unchanged. Repeat with reset in WR_STROBE -> byte updated, all outputs 0 immediately.
- Fetch word at 0xFC -> I_RData equals the preloaded bytes 0xFC..0xFF big-endian. I_Addr 0x02 -> I_Err=1.
